// File: rtl/output_port_allocator.sv
// ============================================================================
// Module      : output_port_allocator
// Description : Round-robin, packet-locked output port allocator with
//               downstream credit gating and a stall watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module output_port_allocator #(
    parameter int NPORT   = 5,
    parameter int CREDITS = 4,
    parameter int CRW     = 3,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORT-1:0]     req,
    input  logic [3*NPORT-1:0]   flit_id,
    input  logic                 credit_in,
    output logic [NPORT-1:0]     grant,
    output logic [2:0]           sel,
    output logic                 fwd,
    output logic [CRW-1:0]       credit_cnt,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [CRW-1:0]   C_CREDITS = CRW'(CREDITS);
    localparam logic [TW-1:0]    C_TIMEOUT = TW'(TIMEOUT);
    localparam logic [2:0]       C_LAST    = 3'(NPORT - 1);
    localparam logic [NPORT-1:0] C_ONE     = NPORT'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [NPORT-1:0] r_grant, w_grant_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic [2:0]       r_rr_ptr, w_rr_nxt;
    logic [CRW-1:0]   r_credit, w_credit_nxt;
    logic [TW-1:0]    r_wd, w_wd_nxt;
    logic             r_terr, w_terr_nxt;

    logic [NPORT-1:0] w_cand;
    logic [NPORT-1:0] w_tail_bits;
    logic [NPORT-1:0] w_unused_body;
    logic             w_sel_req;
    logic             w_sel_tail;
    logic             w_found;
    logic [2:0]       w_winner;
    logic [3:0]       w_idx;
    logic             w_fwd;

    // Body bit carries no information: anything not a tail is forwarded alike.
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_cand
        assign w_cand[gi]        = req[gi] & flit_id[3*gi];
        assign w_tail_bits[gi]   = flit_id[3*gi+2];
        assign w_unused_body[gi] = flit_id[3*gi+1];
    end

    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_tail = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (r_sel == 3'(i)) begin
                w_sel_req  = req[i];
                w_sel_tail = w_tail_bits[i];
            end
        end
    end

    // Search starts just after the last released input, wrapping modulo NPORT.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_idx    = 4'd0;
        for (int k = 1; k <= NPORT; k++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(k);
            if (w_idx >= 4'(NPORT)) begin
                w_idx = w_idx - 4'(NPORT);
            end
            if (!w_found && w_cand[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    assign w_fwd = (r_state == ST_LOCKED) & w_sel_req & (r_credit != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_sel_nxt    = r_sel;
        w_rr_nxt     = r_rr_ptr;
        w_wd_nxt     = r_wd;
        w_terr_nxt   = 1'b0;
        w_credit_nxt = r_credit;

        if (w_fwd && !credit_in) begin
            w_credit_nxt = r_credit - CRW'(1);
        end else if (!w_fwd && credit_in && (r_credit != C_CREDITS)) begin
            w_credit_nxt = r_credit + CRW'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_wd_nxt = '0;
                if (w_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = C_ONE << w_winner;
                    w_sel_nxt   = w_winner;
                end
            end
            ST_LOCKED: begin
                if (w_fwd) begin
                    w_wd_nxt = '0;
                    if (w_sel_tail) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_sel_nxt   = 3'd0;
                        w_rr_nxt    = r_sel;
                    end
                end else if (r_wd == C_TIMEOUT) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_sel_nxt   = 3'd0;
                    w_rr_nxt    = r_sel;
                    w_wd_nxt    = '0;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_sel_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_sel    <= 3'd0;
            r_rr_ptr <= C_LAST;
            r_credit <= C_CREDITS;
            r_wd     <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_credit <= w_credit_nxt;
            r_wd     <= w_wd_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

    assign grant       = r_grant;
    assign sel         = r_sel;
    assign fwd         = w_fwd;
    assign credit_cnt  = r_credit;
    assign busy        = (r_state == ST_LOCKED);
    assign timeout_err = r_terr;

endmodule

`default_nettype wire
